// File: rtl/cpu_pkg.sv
// Shared cpu definitions: instruction-memory geometry and the program-loader state encoding.
package cpu_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int WORD_W      = 16;

    typedef enum logic [2:0] {
        LD_IDLE,
        LD_LEN_HI,
        LD_LEN_LO,
        LD_DATA_HI,
        LD_DATA_LO,
        LD_CKSUM,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    // States in which the loader takes a byte from the stream.
    function automatic logic ld_rx(input ld_state_t s);
        return s inside {LD_LEN_HI, LD_LEN_LO, LD_DATA_HI, LD_DATA_LO, LD_CKSUM};
    endfunction

endpackage

// File: rtl/byte_pack.sv
// Assembles high/low stream bytes into one instruction word and issues a one-cycle
// instruction-memory write with a self-incrementing word address.
module byte_pack #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              hi_en,
    input  logic              lo_en,
    input  logic [7:0]        byte_data,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [15:0]       wdata
);

    logic [7:0] hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hi    <= '0;
            we    <= 1'b0;
            addr  <= '0;
            wdata <= '0;
        end else begin
            we <= lo_en;
            if (hi_en)
                hi <= byte_data;
            if (lo_en)
                wdata <= {hi, byte_data};
            // Words take at least two cycles each, so the bump after a write
            // always lands before the next strobe.
            if (clr)
                addr <= '0;
            else if (we)
                addr <= addr + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Program-load front end: parses a length/data/checksum byte stream, writes instruction
// memory from address 0 and releases the cpu from reset once the checksum matches.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam logic [15:0] MAX_N = 16'(1 << ADDR_W);

    ld_state_t       state;
    logic [7:0]      len_hi;
    logic [7:0]      csum;
    logic [ADDR_W:0] nwords;
    logic [ADDR_W:0] wcnt;
    logic [ADDR_W:0] wnext;
    logic [15:0]     len_rx;
    logic            xfer;
    logic            restart;

    assign xfer    = byte_valid & byte_ready;
    assign len_rx  = {len_hi, byte_data};
    assign wnext   = wcnt + 1'b1;
    assign restart = load_start && (state inside {LD_IDLE, LD_DONE, LD_ERR});

    byte_pack #(.ADDR_W(ADDR_W)) u_pack (
        .clk       (clk),
        .rst       (rst),
        .clr       (restart),
        .hi_en     (xfer && state == LD_DATA_HI),
        .lo_en     (xfer && state == LD_DATA_LO),
        .byte_data (byte_data),
        .we        (imem_we),
        .addr      (imem_addr),
        .wdata     (imem_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= LD_IDLE;
            len_hi     <= '0;
            csum       <= '0;
            nwords     <= '0;
            wcnt       <= '0;
            byte_ready <= 1'b0;
            cpu_rst    <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                LD_IDLE, LD_DONE, LD_ERR: begin
                    if (load_start) begin
                        state      <= LD_LEN_HI;
                        byte_ready <= ld_rx(LD_LEN_HI);
                        cpu_rst    <= 1'b0;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        csum       <= '0;
                        wcnt       <= '0;
                    end
                end
                LD_LEN_HI: begin
                    if (xfer) begin
                        len_hi <= byte_data;
                        csum   <= csum ^ byte_data;
                        state  <= LD_LEN_LO;
                    end
                end
                LD_LEN_LO: begin
                    if (xfer) begin
                        csum <= csum ^ byte_data;
                        if (len_rx > MAX_N) begin
                            state      <= LD_ERR;
                            byte_ready <= ld_rx(LD_ERR);
                            err        <= 1'b1;
                        end else begin
                            nwords <= len_rx[ADDR_W:0];
                            state  <= (len_rx == 16'd0) ? LD_CKSUM : LD_DATA_HI;
                        end
                    end
                end
                LD_DATA_HI: begin
                    if (xfer) begin
                        csum  <= csum ^ byte_data;
                        state <= LD_DATA_LO;
                    end
                end
                LD_DATA_LO: begin
                    if (xfer) begin
                        csum  <= csum ^ byte_data;
                        wcnt  <= wnext;
                        state <= (wnext == nwords) ? LD_CKSUM : LD_DATA_HI;
                    end
                end
                LD_CKSUM: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state   <= LD_DONE;
                            done    <= 1'b1;
                            cpu_rst <= 1'b1;
                        end else begin
                            state <= LD_ERR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= LD_IDLE;
                    byte_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven loads with a write scoreboard,
// plus hand sequences for full-capacity load and reset mid-load.
module tb_imem_loader;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          load_start = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [15:0]   imem_wdata;
    logic          cpu_rst;
    logic          done;
    logic          err;

    imem_loader #(.ADDR_W(AW), .DATA_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int               nb;
        logic [0:15][7:0] b;
        bit               ck;
        bit               bad;
        bit               gaps;
        int               ls_at;
        bit               e_done;
        bit               e_err;
    } vec_t;

    int         checks = 0;
    int         fails = 0;
    wr_t        expq[$];
    logic [7:0] stream[$];
    wr_t        mon_e;
    vec_t       vt[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every observed write must match the next expected word.
    always @(negedge clk) begin
        if (imem_we !== 1'b0) begin
            if (expq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         imem_addr, imem_wdata);
            end else begin
                mon_e = expq.pop_front();
                chk("write_addr", 32'(imem_addr), 32'(mon_e.a));
                chk("write_data", 32'(imem_wdata), 32'(mon_e.d));
            end
        end
    end

    function automatic logic [7:0] xsum();
        logic [7:0] x;
        x = 8'h00;
        foreach (stream[i]) x ^= stream[i];
        return x;
    endfunction

    // Expected writes are every complete word carried by the stream, if N is legal.
    task automatic push_exp();
        int n;
        n = int'({stream[0], stream[1]});
        if (n <= (1 << AW))
            for (int i = 0; i < n; i++)
                if (3 + 2 * i < stream.size())
                    expq.push_back('{a: 8'(i), d: {stream[2 + 2 * i], stream[3 + 2 * i]}});
    endtask

    task automatic start_load();
        byte_valid = 1'b0;
        load_start = 1'b1;
        @(posedge clk);
        #1;
        load_start = 1'b0;
    endtask

    task automatic send(input bit gaps, input int ls_at);
        logic rdy;
        int   t;
        for (int i = 0; i < stream.size(); i++) begin
            if (gaps) begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
            byte_valid = 1'b1;
            byte_data  = stream[i];
            if (i == ls_at) load_start = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                rdy = byte_ready;
                @(posedge clk);
                #1;
                load_start = 1'b0;
                t++;
            end while (!rdy && t < 50);
            if (!rdy) begin
                checks++;
                fails++;
                $display("FAIL xfer_timeout: byte %0d got no ready, expected ready", i);
            end
        end
        byte_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{6, {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, {10{8'h00}}}, 1, 0, 0, -1, 1, 0};
        vt[1] = '{6, {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, {10{8'h00}}}, 1, 1, 0, -1, 0, 1};
        vt[2] = '{2, {8'h00, 8'h00, {14{8'h00}}}, 1, 0, 0, -1, 1, 0};
        vt[3] = '{2, {8'h01, 8'h01, {14{8'h00}}}, 0, 0, 0, -1, 0, 1};
        vt[4] = '{6, {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, {10{8'h00}}}, 1, 0, 1, 2, 1, 0};
        vt[5] = '{8, {8'h00, 8'h03, 8'h00, 8'h01, 8'hFF, 8'hFE, 8'h80, 8'h7F, {8{8'h00}}},
                  1, 0, 1, -1, 1, 0};

        // Reset state
        #12;
        chk("rst_byte_ready", byte_ready, 0);
        chk("rst_imem_we", imem_we, 0);
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_imem_wdata", imem_wdata, 0);
        chk("rst_cpu_rst", cpu_rst, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst = 1'b1;

        // Bytes offered in IDLE are not consumed
        byte_valid = 1'b1;
        byte_data  = 8'h77;
        repeat (3) @(negedge clk);
        chk("idle_ready", byte_ready, 0);
        byte_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            stream.delete();
            for (int i = 0; i < vt[v].nb; i++) stream.push_back(vt[v].b[i]);
            if (vt[v].ck) stream.push_back(xsum() ^ {7'd0, vt[v].bad});
            push_exp();
            start_load();
            chk($sformatf("v%0d_start_ready", v), byte_ready, 1);
            chk($sformatf("v%0d_start_cpu_rst", v), cpu_rst, 0);
            chk($sformatf("v%0d_start_done", v), done, 0);
            chk($sformatf("v%0d_start_err", v), err, 0);
            send(vt[v].gaps, vt[v].ls_at);
            @(negedge clk);
            chk($sformatf("v%0d_done", v), done, 32'(vt[v].e_done));
            chk($sformatf("v%0d_err", v), err, 32'(vt[v].e_err));
            chk($sformatf("v%0d_cpu_rst", v), cpu_rst, 32'(vt[v].e_done));
            chk($sformatf("v%0d_ready", v), byte_ready, 0);
            chk($sformatf("v%0d_pending", v), expq.size(), 0);
            // Terminal state must ignore offered bytes
            byte_valid = 1'b1;
            byte_data  = 8'h5A;
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_hold_ready", v), byte_ready, 0);
            chk($sformatf("v%0d_hold_done", v), done, 32'(vt[v].e_done));
            byte_valid = 1'b0;
        end

        // Full capacity: N = 2**AW, last write at the top address
        stream.delete();
        stream.push_back(8'h01);
        stream.push_back(8'h00);
        for (int i = 0; i < (1 << AW); i++) begin
            stream.push_back(8'(i));
            stream.push_back(8'(i * 7 + 3));
        end
        stream.push_back(xsum());
        push_exp();
        start_load();
        send(0, -1);
        @(negedge clk);
        chk("full_done", done, 1);
        chk("full_cpu_rst", cpu_rst, 1);
        chk("full_pending", expq.size(), 0);

        // Reset between DATA_HI and DATA_LO of word 1
        stream.delete();
        foreach (vt[0].b[i]) if (i < 5) stream.push_back(vt[0].b[i]);
        push_exp();
        start_load();
        send(0, -1);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready", byte_ready, 0);
        chk("mid_rst_we", imem_we, 0);
        chk("mid_rst_addr", imem_addr, 0);
        chk("mid_rst_wdata", imem_wdata, 0);
        chk("mid_rst_cpu_rst", cpu_rst, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_pending", expq.size(), 0);
        repeat (2) begin
            @(negedge clk);
            chk("mid_rst_no_we", imem_we, 0);
        end
        rst = 1'b1;
        stream.delete();
        for (int i = 0; i < 6; i++) stream.push_back(vt[0].b[i]);
        stream.push_back(xsum());
        push_exp();
        start_load();
        send(1, -1);
        @(negedge clk);
        chk("reload_done", done, 1);
        chk("reload_err", err, 0);
        chk("reload_cpu_rst", cpu_rst, 1);
        chk("reload_pending", expq.size(), 0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
